// File: rtl/bf_session_ctrl.sv
`default_nettype none
//==============================================================================
// Module : bf_session_ctrl
// Brief  : Loads a BF program from the UART, zero-fills program RAM, launches
//          the core, routes UART traffic while it runs and reports its status.
// Rev    : 1.0 - initial release
//==============================================================================
module bf_session_ctrl #(
  parameter int         PSIZELOG   = 8,
  parameter logic [7:0] ABORT_CHAR = 8'h1B
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [7:0]          rx_data,
  input  logic                new_rx,
  output logic [7:0]          tx_data,
  output logic                tx_send,
  input  logic                tx_busy,
  output logic                prog_we,
  output logic [PSIZELOG-1:0] prog_addr,
  output logic [7:0]          prog_wdata,
  output logic                core_start,
  output logic                core_abort,
  input  logic                core_running,
  input  logic                core_error,
  output logic [7:0]          core_rx_data,
  output logic                core_new_rx,
  input  logic [7:0]          core_tx_data,
  input  logic                core_tx_send,
  output logic                core_tx_busy,
  output logic [2:0]          state
);

  typedef enum logic [2:0] {
    S_LOAD   = 3'd0,
    S_FILL   = 3'd1,
    S_START  = 3'd2,
    S_RUN    = 3'd3,
    S_REPORT = 3'd4,
    S_NL     = 3'd5
  } state_t;

  localparam logic [7:0] c_CHAR_NL    = 8'h0A;
  localparam logic [7:0] c_STAT_OVF   = 8'h4F;
  localparam logic [7:0] c_STAT_ABORT = 8'h41;
  localparam logic [7:0] c_STAT_ERR   = 8'h45;
  localparam logic [7:0] c_STAT_OK    = 8'h4B;
  localparam logic [PSIZELOG-1:0] c_ADDR_ZERO = '0;
  localparam logic [PSIZELOG-1:0] c_ADDR_ONE  = PSIZELOG'(1);
  localparam logic [PSIZELOG-1:0] c_ADDR_LAST = '1;

  state_t              r_state, w_stateNext;
  logic [PSIZELOG-1:0] r_addr, w_addrNext;
  logic [7:0]          r_status, w_statusNext;
  logic                r_ovf, w_ovfNext;
  logic                r_abort, w_abortNext;
  logic                r_sent, w_sentNext;
  logic                r_runPrev, w_runPrevNext;
  logic                r_seenHigh, w_seenHighNext;
  logic                r_lowOnce, w_lowOnceNext;
  logic                w_isBf;
  logic                w_isAbort;
  logic                w_runExit;

  assign w_isBf    = rx_data inside {8'h2B, 8'h2D, 8'h3C, 8'h3E, 8'h5B, 8'h5D, 8'h2E, 8'h2C};
  assign w_isAbort = new_rx && (rx_data == ABORT_CHAR);
  assign state     = r_state;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_LOAD;
      r_addr     <= c_ADDR_ONE;
      r_status   <= 8'h00;
      r_ovf      <= 1'b0;
      r_abort    <= 1'b0;
      r_sent     <= 1'b0;
      r_runPrev  <= 1'b0;
      r_seenHigh <= 1'b0;
      r_lowOnce  <= 1'b0;
    end else begin
      r_state    <= w_stateNext;
      r_addr     <= w_addrNext;
      r_status   <= w_statusNext;
      r_ovf      <= w_ovfNext;
      r_abort    <= w_abortNext;
      r_sent     <= w_sentNext;
      r_runPrev  <= w_runPrevNext;
      r_seenHigh <= w_seenHighNext;
      r_lowOnce  <= w_lowOnceNext;
    end
  end

  always_comb begin
    w_stateNext    = r_state;
    w_addrNext     = r_addr;
    w_statusNext   = r_status;
    w_ovfNext      = r_ovf;
    w_abortNext    = r_abort;
    w_sentNext     = r_sent;
    w_runPrevNext  = r_runPrev;
    w_seenHighNext = r_seenHigh;
    w_lowOnceNext  = r_lowOnce;
    w_runExit      = 1'b0;
    tx_data        = 8'h00;
    tx_send        = 1'b0;
    prog_we        = 1'b0;
    prog_addr      = r_addr;
    prog_wdata     = 8'h00;
    core_start     = 1'b0;
    core_abort     = 1'b0;
    core_rx_data   = 8'h00;
    core_new_rx    = 1'b0;
    core_tx_busy   = 1'b1;

    case (r_state)
      S_LOAD: begin
        if (new_rx && w_isBf) begin
          if (r_addr != c_ADDR_ZERO) begin
            prog_we    = 1'b1;
            prog_wdata = rx_data;
            w_addrNext = r_addr + c_ADDR_ONE;
          end else begin
            w_ovfNext = 1'b1;
          end
        end else if (new_rx && (rx_data == c_CHAR_NL)) begin
          if (r_ovf) begin
            w_statusNext = c_STAT_OVF;
            w_stateNext  = S_REPORT;
          end else begin
            w_stateNext = S_FILL;
          end
        end
      end

      S_FILL: begin
        if (r_addr == c_ADDR_ZERO) begin
          w_stateNext = S_START;
        end else begin
          prog_we    = 1'b1;
          w_addrNext = r_addr + c_ADDR_ONE;
          if (r_addr == c_ADDR_LAST) w_stateNext = S_START;
        end
      end

      S_START: begin
        core_start     = 1'b1;
        w_runPrevNext  = 1'b0;
        w_seenHighNext = 1'b0;
        w_lowOnceNext  = 1'b0;
        w_stateNext    = S_RUN;
      end

      S_RUN: begin
        core_rx_data   = rx_data;
        core_new_rx    = new_rx && !w_isAbort;
        tx_data        = core_tx_data;
        tx_send        = core_tx_send;
        core_tx_busy   = tx_busy;
        core_abort     = r_abort && core_running;
        w_abortNext    = r_abort || w_isAbort;
        w_runPrevNext  = core_running;
        if (core_running) w_seenHighNext = 1'b1;
        if (!core_running && !r_seenHigh) w_lowOnceNext = 1'b1;
        // A core that never rises within two cycles has finished immediately.
        w_runExit = !core_running &&
                    (r_runPrev || r_abort || (!r_seenHigh && r_lowOnce));
        if (w_runExit) begin
          w_stateNext  = S_REPORT;
          w_statusNext = r_abort ? c_STAT_ABORT : (core_error ? c_STAT_ERR : c_STAT_OK);
        end
      end

      S_REPORT, S_NL: begin
        tx_data = (r_state == S_REPORT) ? r_status : c_CHAR_NL;
        // The cycle after a send is a gap so tx_busy has time to rise.
        if (r_sent) begin
          w_sentNext = 1'b0;
          if (r_state == S_REPORT) begin
            w_stateNext = S_NL;
          end else begin
            w_stateNext = S_LOAD;
            w_addrNext  = c_ADDR_ONE;
            w_ovfNext   = 1'b0;
            w_abortNext = 1'b0;
          end
        end else if (!tx_busy) begin
          tx_send    = 1'b1;
          w_sentNext = 1'b1;
        end
      end

      default: w_stateNext = S_LOAD;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_bf_session_ctrl.sv
`default_nettype none
//==============================================================================
// Module : tb_bf_session_ctrl
// Brief  : Randomised self-checking bench for bf_session_ctrl with a
//          transaction-level model of RAM writes and tx bytes.
// Rev    : 1.0 - initial release
//==============================================================================
module tb_bf_session_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] rx_data = 8'h00;
  logic       new_rx = 1'b0, new_rx3 = 1'b0;
  logic       tx_busy = 1'b0;
  logic       core_running = 1'b0, core_error = 1'b0;
  logic [7:0] core_tx_data = 8'h00;
  logic       core_tx_send = 1'b0;

  logic [7:0] tx_data, prog_wdata, core_rx_data, tx_data3, prog_wdata3, core_rx_data3;
  logic       tx_send, prog_we, core_start, core_abort, core_new_rx, core_tx_busy;
  logic       tx_send3, prog_we3, core_start3, core_abort3, core_new_rx3, core_tx_busy3;
  logic [7:0] prog_addr;
  logic [2:0] prog_addr3;
  logic [2:0] state, state3;

  bf_session_ctrl #(.PSIZELOG(8), .ABORT_CHAR(8'h1B)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .new_rx(new_rx),
    .tx_data(tx_data), .tx_send(tx_send), .tx_busy(tx_busy),
    .prog_we(prog_we), .prog_addr(prog_addr), .prog_wdata(prog_wdata),
    .core_start(core_start), .core_abort(core_abort),
    .core_running(core_running), .core_error(core_error),
    .core_rx_data(core_rx_data), .core_new_rx(core_new_rx),
    .core_tx_data(core_tx_data), .core_tx_send(core_tx_send),
    .core_tx_busy(core_tx_busy), .state(state));

  bf_session_ctrl #(.PSIZELOG(3), .ABORT_CHAR(8'h1B)) dut3 (
    .clk(clk), .rst(rst), .rx_data(rx_data), .new_rx(new_rx3),
    .tx_data(tx_data3), .tx_send(tx_send3), .tx_busy(1'b0),
    .prog_we(prog_we3), .prog_addr(prog_addr3), .prog_wdata(prog_wdata3),
    .core_start(core_start3), .core_abort(core_abort3),
    .core_running(1'b0), .core_error(1'b0),
    .core_rx_data(core_rx_data3), .core_new_rx(core_new_rx3),
    .core_tx_data(8'h00), .core_tx_send(1'b0),
    .core_tx_busy(core_tx_busy3), .state(state3));

  typedef struct { int a; int d; } wr_t;
  wr_t expW[$], expW3[$];
  int  expTx[$], expTx3[$], txLog[$];
  wr_t mw, mw3;
  int  nCmp = 0, nFail = 0;
  int  wrCnt = 0, wrCnt3 = 0, startCnt = 0, startCnt3 = 0;
  bit  runWin = 1'b0, seen40 = 1'b0;

  task automatic fail(input string n, input logic [31:0] act, input logic [31:0] req);
    nCmp++;
    nFail++;
    $display("FAIL %s: got %0h, expected %0h", n, act, req);
  endtask

  task automatic check(input string n, input logic [31:0] act, input logic [31:0] req);
    if (act !== req) fail(n, act, req);
    else nCmp++;
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  function automatic bit isBfChar(input logic [7:0] c);
    string ops = "+-<>[].,";
    for (int i = 0; i < ops.len(); i++) if (ops[i] == c) return 1'b1;
    return 1'b0;
  endfunction

  // Expected RAM writes for a load: program bytes from address 1, then zeros to the top.
  task automatic modelLoad(input string s, input int plog, input bit to3);
    int  depth = 1 << plog;
    int  a = 1;
    bit  ovf = 1'b0;
    wr_t w;
    for (int i = 0; i < s.len(); i++) begin
      if (isBfChar(s[i])) begin
        if (a != 0) begin
          w.a = a; w.d = int'(s[i]);
          if (to3) expW3.push_back(w); else expW.push_back(w);
          a = (a + 1) % depth;
        end else ovf = 1'b1;
      end
    end
    if (!ovf) begin
      while (a != 0) begin
        w.a = a; w.d = 0;
        if (to3) expW3.push_back(w); else expW.push_back(w);
        a = (a + 1) % depth;
      end
    end
  endtask

  task automatic sendStr(input string s, input bit to3);
    string full = {s, "\n"};
    for (int i = 0; i < full.len(); i++) begin
      rx_data = full[i];
      if (to3) new_rx3 = 1'b1; else new_rx = 1'b1;
      tick();
      new_rx = 1'b0;
      new_rx3 = 1'b0;
      repeat ($urandom_range(0, 2)) tick();
    end
  endtask

  task automatic waitStart(input int target);
    int t = 0;
    while (startCnt < target && t < 600) begin tick(); t++; end
    if (startCnt < target) fail("start_timeout", startCnt, target);
  endtask

  task automatic drain(input bit to3);
    int t = 0;
    while (((to3 ? expTx3.size() : expTx.size()) != 0) && t < 300) begin tick(); t++; end
    if (to3 && expTx3.size() != 0) begin fail("tx3_drain", expTx3.size(), 0); expTx3.delete(); end
    if (!to3 && expTx.size() != 0) begin fail("tx_drain", expTx.size(), 0); expTx.delete(); end
    repeat (2) tick();
    check(to3 ? "back_to_load3" : "back_to_load", to3 ? state3 : state, 0);
  endtask

  // mode 0: normal finish, 1: aborted, 2: core never rises. emitByte<0 mixes random traffic.
  task automatic runCore(input int mode, input int nAct, input int err, input int emitByte);
    int t;
    logic [7:0] b;
    runWin = 1'b1;
    if (mode == 2) begin
      expTx.push_back(err != 0 ? 8'h45 : 8'h4B);
      core_error = (err != 0);
      tick(); tick();
      core_error = 1'b0;
    end else begin
      core_running = 1'b1;
      for (int i = 0; i < nAct; i++) begin
        if (emitByte < 0 && $urandom_range(0, 1) == 0) begin
          b = 8'($urandom_range(0, 255));
          if (b == 8'h1B) b = 8'h1C;
          rx_data = b; new_rx = 1'b1;
          #1;
          check("fwd_strobe", core_new_rx, 1);
          check("fwd_data", core_rx_data, b);
          tick();
          new_rx = 1'b0;
        end else begin
          t = 0;
          while (core_tx_busy && t < 50) begin tick(); t++; end
          if (core_tx_busy) fail("core_tx_wait", core_tx_busy, 0);
          check("busy_mirror", core_tx_busy, tx_busy);
          b = (emitByte < 0) ? 8'($urandom_range(0, 255)) : 8'(emitByte);
          expTx.push_back(b);
          core_tx_data = b; core_tx_send = 1'b1;
          tick();
          core_tx_send = 1'b0;
        end
        repeat ($urandom_range(0, 3)) tick();
      end
      if (mode == 1) begin
        expTx.push_back(8'h41);
        rx_data = 8'h1B; new_rx = 1'b1;
        #1 check("abort_hidden", core_new_rx, 0);
        tick();
        new_rx = 1'b0;
        repeat (2) begin check("abort_level", core_abort, 1); tick(); end
        core_error = (err != 0); core_running = 1'b0;
        #1 check("abort_release", core_abort, 0);
        tick();
        core_error = 1'b0;
      end else begin
        expTx.push_back(err != 0 ? 8'h45 : 8'h4B);
        core_error = (err != 0); core_running = 1'b0;
        tick();
        core_error = 1'b0;
      end
    end
    runWin = 1'b0;
    expTx.push_back(8'h0A);
    drain(1'b0);
  endtask

  // UART transmitter: stays busy for a few cycles after each accepted byte.
  initial begin
    int lat;
    forever begin
      @(negedge clk);
      if (tx_send) begin
        lat = $urandom_range(1, 4);
        @(posedge clk); #1 tx_busy = 1'b1;
        repeat (lat) @(posedge clk);
        #1 tx_busy = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (prog_we) begin
      wrCnt++;
      if (prog_addr == 8'd40 && prog_wdata == 8'h00) seen40 = 1'b1;
      if (expW.size() == 0) fail("write_extra", prog_addr, 0);
      else begin
        mw = expW.pop_front();
        check("write_addr", prog_addr, mw.a);
        check("write_data", prog_wdata, mw.d);
      end
    end
    if (tx_send) begin
      txLog.push_back(int'(tx_data));
      check("tx_idle", tx_busy, 0);
      if (expTx.size() == 0) fail("tx_extra", tx_data, 0);
      else check("tx_byte", tx_data, expTx.pop_front());
    end
    if (core_start) startCnt++;
    if (new_rx && !runWin) check("rx_blocked", core_new_rx, 0);

    if (prog_we3) begin
      wrCnt3++;
      if (expW3.size() == 0) fail("write3_extra", prog_addr3, 0);
      else begin
        mw3 = expW3.pop_front();
        check("write3_addr", prog_addr3, mw3.a);
        check("write3_data", prog_wdata3, mw3.d);
      end
    end
    if (tx_send3) begin
      if (expTx3.size() == 0) fail("tx3_extra", tx_data3, 0);
      else check("tx3_byte", tx_data3, expTx3.pop_front());
    end
    if (core_start3) startCnt3++;
    if (new_rx3) check("rx3_blocked", core_new_rx3, 0);
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    string cs = "+-<>[].,ab \t";
    string s;
    int    t;

    repeat (3) tick();
    check("rst_state", state, 0);
    check("rst_we", prog_we, 0);
    check("rst_tx_send", tx_send, 0);
    check("rst_tx_data", tx_data, 0);
    check("rst_start", core_start, 0);
    check("rst_abort", core_abort, 0);
    check("rst_new_rx", core_new_rx, 0);
    check("rst_core_busy", core_tx_busy, 1);
    rst = 1'b1;
    tick();

    // Small RAM: overflow, then a clean load that the idle core finishes at once.
    modelLoad("+++++++++", 3, 1'b1);
    expTx3.push_back(8'h4F); expTx3.push_back(8'h0A);
    wrCnt3 = 0;
    sendStr("+++++++++", 1'b1);
    drain(1'b1);
    check("ovf_writes", wrCnt3, 7);
    check("ovf_nostart", startCnt3, 0);
    modelLoad("+", 3, 1'b1);
    expTx3.push_back(8'h4B); expTx3.push_back(8'h0A);
    sendStr("+", 1'b1);
    drain(1'b1);
    check("small_start", startCnt3, 1);
    check("small_fill_done", expW3.size(), 0);

    modelLoad("+.", 8, 1'b0);
    wrCnt = 0;
    sendStr("+.", 1'b0);
    waitStart(1);
    check("load1_writes", wrCnt, 255);
    txLog.delete();
    runCore(0, 1, 0, 8'h58);
    check("run1_len", txLog.size(), 3);
    if (txLog.size() == 3) begin
      check("run1_b0", txLog[0], 8'h58);
      check("run1_b1", txLog[1], 8'h4B);
      check("run1_b2", txLog[2], 8'h0A);
    end

    modelLoad("a+ b", 8, 1'b0);
    wrCnt = 0;
    sendStr("a+ b", 1'b0);
    waitStart(2);
    check("load2_writes", wrCnt, 255);
    txLog.delete();
    runCore(1, 0, 0, 8'h58);
    check("abort_len", txLog.size(), 2);
    if (txLog.size() == 2) begin
      check("abort_b0", txLog[0], 8'h41);
      check("abort_b1", txLog[1], 8'h0A);
    end

    // Reset in the middle of the zero fill.
    modelLoad("+.", 8, 1'b0);
    seen40 = 1'b0;
    sendStr("+.", 1'b0);
    t = 0;
    while (!seen40 && t < 400) begin tick(); t++; end
    if (!seen40) fail("fill40_timeout", 0, 1);
    rst = 1'b0;
    #1;
    check("midrst_we", prog_we, 0);
    check("midrst_state", state, 0);
    expW.delete();
    tick();
    rst = 1'b1;
    tick();
    modelLoad("+", 8, 1'b0);
    wrCnt = 0;
    sendStr("+", 1'b0);
    waitStart(3);
    check("load3_writes", wrCnt, 255);
    runCore(0, 2, 1, -1);

    for (int k = 0; k < 8; k++) begin
      s = "";
      repeat ($urandom_range(1, 12)) begin
        t = $urandom_range(0, cs.len() - 1);
        s = {s, cs.substr(t, t)};
      end
      modelLoad(s, 8, 1'b0);
      sendStr(s, 1'b0);
      waitStart(4 + k);
      runCore($urandom_range(0, 2), $urandom_range(1, 4), $urandom_range(0, 1), -1);
    end
    check("start_total", startCnt, 11);
    check("writes_consumed", expW.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nFail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/bf_session_ctrl.md
Name: bf_session_ctrl

Overview:
- Session controller for the brainfuck core: loads a program from the UART into program RAM, zero-fills the unused RAM, starts the core, and routes UART traffic between itself and the core.
- Reports run status over tx when the core stops, then returns to loading.
- Sits between the UART rx/tx pair and the core; it is the only owner of the program-RAM write port and of core_start.

Parameters:
PSIZELOG, 8, log2 of program RAM depth; the core finishes when its pc wraps to address 0.
ABORT_CHAR, 8'h1B, rx byte that aborts a running program.

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset
rx_data  in  8  UART received byte
new_rx  in  1  one-cycle strobe: rx_data valid
tx_data  out  8  byte to UART tx
tx_send  out  1  one-cycle send strobe
tx_busy  in  1  UART tx busy
prog_we  out  1  program RAM write enable
prog_addr  out  PSIZELOG  program RAM write address
prog_wdata  out  8  program RAM write data
core_start  out  1  one-cycle start pulse to core
core_abort  out  1  level; forces core to stop
core_running  in  1  core running flag
core_error  in  1  core error flag, valid in the cycle core_running falls
core_rx_data  out  8  rx byte forwarded to core
core_new_rx  out  1  rx strobe forwarded to core
core_tx_data  in  8  core output byte
core_tx_send  in  1  core send strobe
core_tx_busy  out  1  tx_busy as seen by core
state  out  3  current FSM state, for LEDs

Behaviour:
- Reset values: state=LOAD, addr=1, ovf=0, abort latch=0. All strobes and prog_we are 0; tx_data=0; core_abort=0.
- States: LOAD, FILL, START, RUN, REPORT, NL.
- LOAD:
  - On new_rx with a byte in the set + - < > [ ] . , and addr!=0: write it at addr (prog_we high for that cycle only), then addr+1 with wrap.
  - Other bytes are ignored, except '\n'.
  - A BF byte arriving when addr==0 (RAM full) is dropped and ovf is set.
  - On '\n': if ovf, go to REPORT with status 'O'; otherwise go to FILL.
- FILL:
  - Write 8'h00 at addr once per cycle, addr+1, until the write at address 2^PSIZELOG-1 completes, then go to START.
  - If addr is already 0 on entry, go straight to START.
- START:
  - Assert core_start for exactly 1 cycle, then go to RUN.
  - The core's pc begins at 1.
- RUN:
  - core_rx_data=rx_data.
  - core_new_rx=new_rx, except when rx_data==ABORT_CHAR; the abort byte is never forwarded.
  - tx_data/tx_send mirror core_tx_data/core_tx_send combinationally; core_tx_busy=tx_busy.
  - ABORT_CHAR sets the abort latch, and core_abort stays high until core_running is low.
  - Exit to REPORT on the cycle after core_running is seen falling, or, if the latch is set, once core_running is low.
  - Status byte: 'A' if aborted, else 'E' if core_error, else 'K'.
  - A core_running low held for 2 cycles after START with no rise counts as immediate finish.
- REPORT / NL:
  - Wait until tx_busy==0, then pulse tx_send for 1 cycle with tx_data=status (REPORT) or 8'h0A (NL).
  - After the send, wait one cycle before sampling tx_busy again.
  - REPORT→NL→LOAD.
  - On entry to LOAD: addr=1, ovf=0, abort latch=0.
- Outside RUN:
  - core_new_rx=0 and core_tx_busy=1.
  - Core tx strobes are ignored.
  - rx bytes in FILL, START, REPORT and NL are discarded.
- Address arithmetic is PSIZELOG bits, wrapping modulo 2^PSIZELOG. Address 0 is never written.
- Asynchronous reset mid-operation (any state) returns to the reset values immediately.
  - A partially written program is not cleared; the next load's FILL overwrites it.

Test Plan:
- Load "+." then '\n' → writes 8'h2B@1, 8'h2E@2, then 8'h00 at 3..255 (253 cycles); one core_start pulse; no forwarding before START.
- Load "a+ b\n" → only '+' written, at addr 1; 'a', ' ', 'b' produce no prog_we.
- RUN, core emits 'X' then drops core_running with core_error=0 → tx 'X', 'K', 8'h0A in order; each tx_send only while tx_busy=0; back in LOAD with addr=1.
- RUN, inject 8'h1B → core_new_rx stays 0 for it; core_abort high until core_running=0; tx 'A', 8'h0A.
- PSIZELOG=3: send 9 '+' then '\n' → addresses 1..7 written; 8th and 9th dropped; tx 'O', 8'h0A; no core_start.
- Pull rst low during FILL at addr 40 → next cycle prog_we=0 and state=LOAD; new load "+\n" fills from addr 2.
